fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipeline. It drives the `Inst` word (`pc`, `inst`) consumed by the decode stage. It keeps the program counter and issues word reads to instruction memory over a req/ack handshake. It also applies redirects from branch resolution and decode-stage jumps, honours load-use stalls, and stops fetching after a halt opcode.

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word reads to instruction
// memory and presents {pc, inst} to decode, with redirect, stall skid and halt handling.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        do_branch,
  input  logic [15:0] branch_address,
  input  logic        do_jump,
  input  logic [15:0] jump_address,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [31:0] to_inst,
  output logic        to_valid,
  output logic        is_halted
);

  typedef enum logic [1:0] {StRun, StSquash, StHold, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_q, skid_d;

  logic        redirect;
  logic [15:0] target;
  logic        ack;
  logic        data_halt;
  logic        skid_halt;

  assign redirect  = do_branch | do_jump;
  // The branch is older than the decode-stage jump, so it takes precedence.
  assign target    = do_branch ? branch_address : jump_address;
  assign ack       = req_q & imem_ack;
  assign data_halt = (imem_data[15:12] == 4'hF);
  assign skid_halt = (skid_q[15:12] == 4'hF);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    skid_d  = skid_q;

    if (redirect) begin
      inst_d  = '0;
      valid_d = 1'b0;
      skid_d  = '0;
      pc_d    = target;
      if (req_q && !imem_ack) begin
        // Request cannot be aborted: keep the address stable and drop the data on ack.
        state_d = StSquash;
      end else begin
        state_d = StRun;
        addr_d  = target;
        req_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (!stall) begin
            inst_d  = '0;
            valid_d = 1'b0;
          end
          if (ack) begin
            addr_d = addr_q + 16'd1;
            pc_d   = addr_q + 16'd1;
            if (stall) begin
              skid_d  = {addr_q, imem_data};
              state_d = StHold;
              req_d   = 1'b0;
            end else begin
              inst_d  = {addr_q, imem_data};
              valid_d = 1'b1;
              if (data_halt) begin
                state_d = StHalted;
                req_d   = 1'b0;
              end
            end
          end else begin
            req_d = 1'b1;
          end
        end
        StSquash: begin
          if (!stall) begin
            inst_d  = '0;
            valid_d = 1'b0;
          end
          if (ack) begin
            state_d = StRun;
            addr_d  = pc_q;
            req_d   = 1'b1;
          end
        end
        StHold: begin
          if (!stall) begin
            inst_d  = skid_q;
            valid_d = 1'b1;
            skid_d  = '0;
            if (skid_halt) begin
              state_d = StHalted;
            end else begin
              state_d = StRun;
              req_d   = 1'b1;
            end
          end
        end
        StHalted: begin
          if (!stall) begin
            inst_d  = '0;
            valid_d = 1'b0;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    imem_req  = req_q;
    imem_addr = addr_q;
    to_inst   = inst_q;
    to_valid  = valid_q;
    is_halted = (state_q == StHalted);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder with configurable latency, a consumed-instruction
// scoreboard fed from a program-order reference stream, plus directed timing checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        do_branch;
  logic [15:0] branch_address;
  logic        do_jump;
  logic [15:0] jump_address;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [31:0] to_inst;
  logic        to_valid;
  logic        is_halted;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .do_branch     (do_branch),
    .branch_address(branch_address),
    .do_jump       (do_jump),
    .jump_address  (jump_address),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .to_inst       (to_inst),
    .to_valid      (to_valid),
    .is_halted     (is_halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [65536];
  logic [31:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int pops = 0;
  bit resp_en = 1'b1;
  int lat_mode = 0;

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'hF) w[15:12] = 4'h7;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: after a redirect (or reset) decode must see consecutive words from the target.
  task automatic push_stream(input logic [15:0] start, input int n);
    logic [15:0] a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = start + 16'(i);
      exp_q.push_back({a, mem[a]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    exp_q.delete();
    pops = 0;
    rst = 1'b1;
  endtask

  // Memory responder: acks each request after lat_mode cycles (random 0..2 when negative).
  initial begin : responder
    bit          busy;
    int          wait_left;
    logic [15:0] cur_addr;
    busy = 1'b0;
    wait_left = 0;
    cur_addr = '0;
    imem_ack = 1'b0;
    imem_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!resp_en) begin
        busy = 1'b0;
      end else if (!imem_req) begin
        busy = 1'b0;
        imem_ack = 1'b0;
        imem_data = 16'($urandom);
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cur_addr = imem_addr;
          wait_left = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
        end else begin
          chk("addr_stable", 32'(imem_addr), 32'(cur_addr));
        end
        if (wait_left == 0) begin
          imem_ack = 1'b1;
          imem_data = mem[imem_addr];
          busy = 1'b0;
        end else begin
          imem_ack = 1'b0;
          imem_data = 16'($urandom);
          wait_left--;
        end
      end
    end
  end

  // Decode consumes to_inst whenever it is valid and not stalled.
  always @(negedge clk) begin
    if (rst && to_valid && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none @%0t", to_inst, $time);
      end else begin
        chk("inst_stream", to_inst, exp_q.pop_front());
        pops++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int pj;
    bit redir;
    int kind;
    logic [15:0] tb_t;
    logic [15:0] tj_t;
    rst = 1'b0;
    stall = 1'b0;
    do_branch = 1'b0;
    do_jump = 1'b0;
    branch_address = '0;
    jump_address = '0;
    for (int i = 0; i < 65536; i++) mem[i[15:0]] = rand_word();
    mem[0] = 16'h5101;
    mem[1] = 16'h5202;
    mem[2] = 16'h1120;
    mem[3] = 16'hF000;

    // Reset values, zero-wait stream, halt.
    lat_mode = 0;
    tick();
    do_reset();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_inst", to_inst, 32'd0);
    chk("rst_valid", 32'(to_valid), 32'd0);
    chk("rst_halted", 32'(is_halted), 32'd0);
    push_stream(16'h0000, 4);
    tick();
    chk("first_req", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0000});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("zw_valid", 32'(to_valid), 32'd1);
      chk("zw_inst", to_inst, {16'(i), mem[i]});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halted_noreq", 32'({is_halted, imem_req}), 32'b10);
    end
    chk("halt_stream_len", 32'(pops), 32'd4);

    // Branch out of HALTED.
    do_branch = 1'b1;
    branch_address = 16'h0010;
    tick();
    do_branch = 1'b0;
    push_stream(16'h0010, 300);
    chk("resume_halted", 32'(is_halted), 32'd0);
    chk("resume_addr", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0010});
    for (int i = 0; i < 10; i++) tick();
    chk("resume_progress", 32'(pops >= 9), 32'd1);

    // Two-cycle memory: one output every third cycle.
    lat_mode = 2;
    do_reset();
    push_stream(16'h0000, 4);
    for (int i = 0; i < 20 && !to_valid; i++) tick();
    chk("lat_first_valid", 32'(to_valid), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("lat_gap1", 32'(to_valid), 32'd0);
      tick();
      chk("lat_gap2", 32'(to_valid), 32'd0);
      tick();
      chk("lat_pulse", 32'(to_valid), 32'd1);
    end

    // Stall while the pc=5 ack arrives.
    mem[3] = rand_word();
    lat_mode = 0;
    do_reset();
    push_stream(16'h0000, 300);
    for (int i = 0; i < 30 && !(to_valid && to_inst[31:16] == 16'd4); i++) tick();
    chk("stall_setup", 32'(to_valid && to_inst[31:16] == 16'd4), 32'd1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", to_inst, {16'd4, mem[4]});
      chk("stall_noreq", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("skid_drain", {31'd0, to_valid}, 32'd1);
    chk("skid_inst", to_inst, {16'd5, mem[5]});
    tick();
    chk("after_skid", to_inst, {16'd6, mem[6]});

    // Jump while pc=5 is outstanding.
    lat_mode = 3;
    do_reset();
    push_stream(16'h0000, 300);
    for (int i = 0; i < 60 && !(imem_req && imem_addr == 16'd5); i++) tick();
    chk("jump_setup", 32'(imem_req && imem_addr == 16'd5), 32'd1);
    do_jump = 1'b1;
    jump_address = 16'h0020;
    tick();
    do_jump = 1'b0;
    pj = pops;
    push_stream(16'h0020, 300);
    chk("jump_nop", to_inst, 32'd0);
    chk("jump_nop_valid", 32'(to_valid), 32'd0);
    chk("squash_addr", 32'(imem_addr), 32'd5);
    for (int i = 0; i < 10 && imem_addr == 16'd5; i++) tick();
    chk("jump_target", 32'(imem_addr), 32'h0020);
    for (int i = 0; i < 20; i++) tick();
    chk("jump_progress", 32'(pops > pj), 32'd1);

    // Branch and jump together; zero-wait target timing.
    lat_mode = 0;
    do_reset();
    push_stream(16'h0000, 300);
    for (int i = 0; i < 20 && !(to_valid && to_inst[31:16] == 16'd2); i++) tick();
    chk("both_setup", 32'(to_valid && to_inst[31:16] == 16'd2), 32'd1);
    do_branch = 1'b1;
    do_jump = 1'b1;
    branch_address = 16'h0040;
    jump_address = 16'h0020;
    tick();
    do_branch = 1'b0;
    do_jump = 1'b0;
    push_stream(16'h0040, 300);
    chk("both_addr", 32'(imem_addr), 32'h0040);
    chk("both_nop", {31'd0, to_valid}, 32'd0);
    tick();
    chk("both_target", to_inst, {16'h0040, mem[16'h0040]});
    chk("both_target_valid", 32'(to_valid), 32'd1);

    // Reset mid-request, then a stray ack.
    lat_mode = 3;
    do_reset();
    push_stream(16'h0000, 300);
    for (int i = 0; i < 80 && !(imem_req && imem_addr == 16'd9); i++) tick();
    chk("rst_mid_setup", 32'(imem_req && imem_addr == 16'd9), 32'd1);
    rst = 1'b0;
    resp_en = 1'b0;
    imem_ack = 1'b0;
    tick();
    exp_q.delete();
    chk("rst2_addr", 32'(imem_addr), 32'd0);
    chk("rst2_req", 32'(imem_req), 32'd0);
    chk("rst2_inst", to_inst, 32'd0);
    chk("rst2_flags", 32'({to_valid, is_halted}), 32'd0);
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_data = 16'h5555;
    tick();
    imem_ack = 1'b0;
    resp_en = 1'b1;
    pops = 0;
    push_stream(16'h0000, 300);
    chk("stray_ack_valid", 32'(to_valid), 32'd0);
    chk("stray_ack_addr", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0000});
    for (int i = 0; i < 20; i++) tick();
    chk("rst_progress", 32'(pops > 0), 32'd1);

    // Random latency, stall and redirects against the program-order stream.
    lat_mode = -1;
    do_reset();
    push_stream(16'h0000, 300);
    for (int c = 0; c < 1500; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      redir = (c == 10) || ($urandom_range(0, 39) == 0);
      kind = int'($urandom_range(0, 2));
      tb_t = 16'($urandom);
      tj_t = 16'($urandom);
      if (c == 10) begin
        kind = 0;
        tb_t = 16'hFFFE;
      end
      if (redir) begin
        do_branch = (kind != 1);
        do_jump = (kind != 0);
        branch_address = tb_t;
        jump_address = tj_t;
      end
      tick();
      do_branch = 1'b0;
      do_jump = 1'b0;
      if (redir) push_stream((kind != 1) ? tb_t : tj_t, 300);
    end
    stall = 1'b0;
    chk("random_progress", 32'(pops >= 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
